parking_ctrl: RTL

Parametrised parking-lot gate controller. It tracks free slots for a lot of `SLOTS` spaces and arbitrates enter/exit sensor requests. It drives a gate door that stays open for a fixed number of cycles per accepted transaction. It sits between the gate sensors and the door actuator/display logic, and generalises the fixed 4-slot controller with configurable capacity, door timing, explicit accept/reject signalling and a defined simultaneous enter/exit policy.

---
 rtl/parking_ctrl_if.sv | 46 ++++
 rtl/parking_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/parking_ctrl_if.sv
// Gate-side bundle for parking_ctrl: sensor requests in, slot status,
// door drive and accept/reject pulses out.
// The optional total_in statistics port exists only when PARKING_STATS_EN
// is defined.
interface parking_ctrl_if #(
  parameter int SLOTS = 4
) ();
  localparam int CW = $clog2(SLOTS + 1);

  logic          enter;
  logic          exit;
  logic [CW-1:0] free;
  logic          full;
  logic          empty;
  logic          open_door;
  logic          ack_enter;
  logic          ack_exit;
  logic          reject;
`ifdef PARKING_STATS_EN
  logic [15:0]   total_in;
`endif

`ifdef PARKING_STATS_EN
  // Sensor / supervisor side
  modport master (
    output enter, exit,
    input  free, full, empty, open_door, ack_enter, ack_exit, reject, total_in
  );
  // Controller side
  modport slave (
    input  enter, exit,
    output free, full, empty, open_door, ack_enter, ack_exit, reject, total_in
  );
`else
  // Sensor / supervisor side
  modport master (
    output enter, exit,
    input  free, full, empty, open_door, ack_enter, ack_exit, reject
  );
  // Controller side
  modport slave (
    input  enter, exit,
    output free, full, empty, open_door, ack_enter, ack_exit, reject
  );
`endif
endinterface

// File: rtl/parking_ctrl.sv
// Parking-lot gate controller: tracks free slots, arbitrates enter/exit
// requests, holds the door open for DOOR_HOLD cycles per accepted
// transaction, and pulses ack/reject for one cycle.
// Optional feature macro: PARKING_STATS_EN adds a saturating 16-bit
// count of accepted entries on bus.total_in.
module parking_ctrl #(
  parameter int SLOTS     = 4,
  parameter int DOOR_HOLD = 3
) (
  input  logic          CLK,
  input  logic          RST,
  parking_ctrl_if.slave bus
);
  localparam int CW = $clog2(SLOTS + 1);
  localparam int HW = (DOOR_HOLD > 1) ? $clog2(DOOR_HOLD) : 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(SLOTS);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(DOOR_HOLD - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [CW-1:0] free_q, free_d;
  logic          open_q, open_d;
  logic          ack_en_q, ack_en_d;
  logic          ack_ex_q, ack_ex_d;
  logic          rej_q, rej_d;
  logic          en_ok_s;
  logic          ex_ok_s;

  // Acceptance rules: an exit frees a slot, so a simultaneous enter is
  // still accepted at a full lot; an exit at an empty lot is never valid.
  always_comb begin
    ex_ok_s = bus.exit && (free_q != FULL_CNT);
    en_ok_s = bus.enter && ((free_q != {CW{1'b0}}) || ex_ok_s);
  end

  // Next-state logic for the door FSM, slot counter and pulses.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    free_d   = free_q;
    open_d   = open_q;
    ack_en_d = 1'b0;
    ack_ex_d = 1'b0;
    rej_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ack_en_d = en_ok_s;
        ack_ex_d = ex_ok_s;
        rej_d    = (bus.enter && !en_ok_s) || (bus.exit && !ex_ok_s);
        if (en_ok_s && !ex_ok_s) begin
          free_d = free_q - {{(CW-1){1'b0}}, 1'b1};
        end else if (ex_ok_s && !en_ok_s) begin
          free_d = free_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
          free_d = free_q;
        end
        if (en_ok_s || ex_ok_s) begin
          state_d = ST_OPEN;
          hold_d  = HOLD_LOAD;
          open_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          hold_d  = {HW{1'b0}};
          open_d  = 1'b0;
        end
      end
      ST_OPEN: begin
        // Requests are ignored while the door is open.
        if (hold_q == {HW{1'b0}}) begin
          state_d = ST_IDLE;
          open_d  = 1'b0;
        end else begin
          state_d = ST_OPEN;
          hold_d  = hold_q - {{(HW-1){1'b0}}, 1'b1};
          open_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = {HW{1'b0}};
        open_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset to an empty lot, door closed.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      hold_q   <= {HW{1'b0}};
      free_q   <= FULL_CNT;
      open_q   <= 1'b0;
      ack_en_q <= 1'b0;
      ack_ex_q <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      free_q   <= free_d;
      open_q   <= open_d;
      ack_en_q <= ack_en_d;
      ack_ex_q <= ack_ex_d;
      rej_q    <= rej_d;
    end
  end

`ifdef PARKING_STATS_EN
  logic [15:0] total_q, total_d;

  // Saturating count of accepted entries, stepping with ack_enter.
  always_comb begin
    if (ack_en_d && (total_q != 16'hFFFF)) begin
      total_d = total_q + 16'd1;
    end else begin
      total_d = total_q;
    end
  end

  // Entry statistics register, cleared by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      total_q <= 16'd0;
    end else begin
      total_q <= total_d;
    end
  end

  assign bus.total_in = total_q;
`endif

  assign bus.free      = free_q;
  assign bus.full      = (free_q == {CW{1'b0}});
  assign bus.empty     = (free_q == FULL_CNT);
  assign bus.open_door = open_q;
  assign bus.ack_enter = ack_en_q;
  assign bus.ack_exit  = ack_ex_q;
  assign bus.reject    = rej_q;
endmodule
